// File: rtl/median_filter_pkg.sv
// Shared types for the filter datapath.
// Pixel format, streamer states and width helper.
package median_filter_pkg;

  localparam int PIXEL_W = 24;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    GAP,
    DRAIN,
    DONE
  } stream_state_t;

  // Counter width for a bound, never below one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_valid_if.sv
// Valid-only pixel stream, no backpressure.
// Master drives valid and pixel; slave must accept every valid.
interface pixel_valid_if;
  import median_filter_pkg::*;

  logic   valid;
  pixel_t pixel;

  modport master (
    output valid,
    output pixel
  );

  modport slave (
    input valid,
    input pixel
  );

endinterface

// File: rtl/raster_counter.sv
// Raster x/y counter with line and frame wrap.
// Advances one position per enabled cycle.
module raster_counter
  import median_filter_pkg::*;
#(
  parameter int LEN    = 1080,
  parameter int HEIGHT = 720,
  localparam int XW    = cw(LEN),
  localparam int YW    = cw(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          eol,
  output logic          eof
);

  localparam logic [XW-1:0] X_LAST = XW'(LEN - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  assign eol = (x == X_LAST);
  assign eof = eol && (y == Y_LAST);

  // Step through the frame, wrapping x per line and y per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (eol) begin
        x <= '0;
        y <= eof ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// Frame memory reader driving a pixel_valid_if master.
// Raster order, optional idle gap between lines, done pulse at end.
module frame_streamer
  import median_filter_pkg::*;
#(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int LINE_GAP     = 0,
  parameter int MEM_ADDR_W   = cw(IMAGE_LEN * IMAGE_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  mem_en_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  input  pixel_t                mem_data_i,
  pixel_valid_if.master         pixel_valid_if_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int XW = cw(IMAGE_LEN);
  localparam int YW = cw(IMAGE_HEIGHT);
  localparam int GW = cw(LINE_GAP);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  stream_state_t   state;
  logic [GW-1:0]   gap_cnt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            eol;
  logic            eof;
  logic            v1;
  logic            sof1;
  logic            eol1;

  raster_counter #(
    .LEN    (IMAGE_LEN),
    .HEIGHT (IMAGE_HEIGHT)
  ) u_rc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .en    (state == READ),
    .x     (x),
    .y     (y),
    .eol   (eol),
    .eof   (eof)
  );

  // Sequencer: READ is exactly the set of cycles with mem_en_o high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
      gap_cnt    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state      <= READ;
            mem_en_o   <= 1'b1;
            mem_addr_o <= '0;
            busy_o     <= 1'b1;
          end
        end
        READ: begin
          if (!eof) begin
            mem_addr_o <= mem_addr_o + 1'b1;
          end
          if (eof) begin
            state    <= DRAIN;
            mem_en_o <= 1'b0;
          end else if (eol && (LINE_GAP > 0)) begin
            state    <= GAP;
            mem_en_o <= 1'b0;
            gap_cnt  <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= READ;
            mem_en_o <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!v1) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_en_o <= 1'b0;
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage output pipe: read cycle, memory data, output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1                     <= 1'b0;
      sof1                   <= 1'b0;
      eol1                   <= 1'b0;
      pixel_valid_if_o.valid <= 1'b0;
      pixel_valid_if_o.pixel <= '0;
      sof_o                  <= 1'b0;
      eol_o                  <= 1'b0;
    end else begin
      v1                     <= mem_en_o;
      sof1                   <= mem_en_o && (x == '0) && (y == '0);
      eol1                   <= mem_en_o && eol;
      pixel_valid_if_o.valid <= v1;
      sof_o                  <= sof1;
      eol_o                  <= eol1;
      if (v1) begin
        pixel_valid_if_o.pixel <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer.
// Three instances: 4x3 gap 2, 4x3 gap 0, 1x1.
module tb_frame_streamer;
  import median_filter_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        sof;
    logic        eol;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  logic start_a, start_b, start_c;

  logic       en_a, en_b, en_c;
  logic [3:0] addr_a, addr_b;
  logic [0:0] addr_c;
  pixel_t     rd_a = '0, rd_b = '0, rd_c = '0;
  logic       sof_a, sof_b, sof_c;
  logic       eol_a, eol_b, eol_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  pixel_valid_if pa ();
  pixel_valid_if pb ();
  pixel_valid_if pc ();

  ev_t rq[3][$];
  ev_t vq[3][$];
  ev_t dq[3][$];

  int npass = 0;
  int ntot  = 0;

  function automatic pixel_t pix(input int a);
    pixel_t p;
    p.red   = 8'(a);
    p.green = 8'(a + 16);
    p.blue  = 8'(a + 32);
    return p;
  endfunction

  frame_streamer #(
    .IMAGE_LEN(4), .IMAGE_HEIGHT(3), .LINE_GAP(2), .MEM_ADDR_W(4)
  ) ua (
    .clk(clk), .rst_n(rst_n), .start_i(start_a),
    .mem_en_o(en_a), .mem_addr_o(addr_a), .mem_data_i(rd_a),
    .pixel_valid_if_o(pa), .sof_o(sof_a), .eol_o(eol_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  frame_streamer #(
    .IMAGE_LEN(4), .IMAGE_HEIGHT(3), .LINE_GAP(0), .MEM_ADDR_W(4)
  ) ub (
    .clk(clk), .rst_n(rst_n), .start_i(start_b),
    .mem_en_o(en_b), .mem_addr_o(addr_b), .mem_data_i(rd_b),
    .pixel_valid_if_o(pb), .sof_o(sof_b), .eol_o(eol_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  frame_streamer #(
    .IMAGE_LEN(1), .IMAGE_HEIGHT(1), .LINE_GAP(0), .MEM_ADDR_W(1)
  ) uc (
    .clk(clk), .rst_n(rst_n), .start_i(start_c),
    .mem_en_o(en_c), .mem_addr_o(addr_c), .mem_data_i(rd_c),
    .pixel_valid_if_o(pc), .sof_o(sof_c), .eol_o(eol_c),
    .busy_o(busy_c), .done_o(done_c)
  );

  always @(posedge clk) if (en_a) rd_a <= pix(int'(addr_a));
  always @(posedge clk) if (en_b) rd_b <= pix(int'(addr_b));
  always @(posedge clk) if (en_c) rd_c <= pix(int'(addr_c));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
  endtask

  task automatic extra(input string nm, input int id);
    ntot++;
    $display("FAIL %s dut=%0d cyc=%0d got=event want=none", nm, id, cyc);
  endtask

  task automatic push_frame(input int id, input int k, input int l,
                            input int h, input int g, input int cut);
    ev_t e;
    int rc, a;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < l; xx++) begin
        rc = k + 1 + yy * (l + g) + xx;
        a  = yy * l + xx;
        e.cyc = rc; e.data = 32'(a); e.sof = 1'b0; e.eol = 1'b0;
        if (rc < cut) rq[id].push_back(e);
        e.cyc  = rc + 2;
        e.data = {8'h0, pix(a)};
        e.sof  = (a == 0);
        e.eol  = (xx == l - 1);
        if (rc + 2 < cut) vq[id].push_back(e);
      end
    end
    e.cyc = k + 3 + l * h + (h - 1) * g;
    e.data = '0; e.sof = 1'b0; e.eol = 1'b0;
    if (e.cyc < cut) dq[id].push_back(e);
  endtask

  task automatic mon(input int id, input logic en, input int addr,
                     input logic v, input pixel_t px, input logic sof,
                     input logic eol, input logic done);
    ev_t e;
    if (en) begin
      if (rq[id].size() == 0) extra("read_extra", id);
      else begin
        e = rq[id].pop_front();
        chk($sformatf("read%0d", id), {32'(cyc), 32'(addr)},
            {32'(e.cyc), e.data});
      end
    end
    if (v) begin
      if (vq[id].size() == 0) extra("valid_extra", id);
      else begin
        e = vq[id].pop_front();
        chk($sformatf("valid%0d", id), {16'(cyc), px, sof, eol},
            {16'(e.cyc), e.data[23:0], e.sof, e.eol});
      end
    end
    if (done) begin
      if (dq[id].size() == 0) extra("done_extra", id);
      else begin
        e = dq[id].pop_front();
        chk($sformatf("done%0d", id), 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  always @(negedge clk)
    mon(0, en_a, int'(addr_a), pa.valid, pa.pixel, sof_a, eol_a, done_a);
  always @(negedge clk)
    mon(1, en_b, int'(addr_b), pb.valid, pb.pixel, sof_b, eol_b, done_b);
  always @(negedge clk)
    mon(2, en_c, int'(addr_c), pc.valid, pc.pixel, sof_c, eol_c, done_c);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  localparam int NOCUT = 1 << 30;

  initial begin
    int k;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) tick();
    chk("rst_a", 64'({en_a, addr_a, pa.valid, pa.pixel, sof_a, eol_a,
                      busy_a, done_a}), 64'(0));
    chk("rst_b", 64'({en_b, addr_b, pb.valid, pb.pixel, sof_b, eol_b,
                      busy_b, done_b}), 64'(0));
    chk("rst_c", 64'({en_c, addr_c, pc.valid, pc.pixel, sof_c, eol_c,
                      busy_c, done_c}), 64'(0));
    rst_n = 1'b1;
    tick();

    // single frame on all three instances
    k = cyc;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    push_frame(0, k, 4, 3, 2, NOCUT);
    push_frame(1, k, 4, 3, 0, NOCUT);
    push_frame(2, k, 1, 1, 0, NOCUT);
    chk("busy_k", 64'(busy_a), 64'(0));
    tick();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    chk("busy_k1", 64'(busy_a), 64'(1));
    wait_to(k + 19);
    chk("busy_k19", 64'(busy_a), 64'(1));
    tick();
    chk("busy_k20", 64'(busy_a), 64'(0));
    wait_to(k + 25);

    // starts while busy are ignored
    k = cyc;
    start_a = 1'b1;
    push_frame(0, k, 4, 3, 2, NOCUT);
    tick();
    start_a = 1'b0;
    wait_to(k + 5);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_to(k + 8);
    start_a = 1'b1;
    wait_to(k + 13);
    start_a = 1'b0;
    wait_to(k + 25);

    // start held high: back-to-back frames
    k = cyc;
    start_a = 1'b1;
    push_frame(0, k, 4, 3, 2, NOCUT);
    push_frame(0, k + 20, 4, 3, 2, NOCUT);
    wait_to(k + 30);
    start_a = 1'b0;
    wait_to(k + 50);

    // asynchronous reset mid-frame
    k = cyc;
    start_a = 1'b1;
    push_frame(0, k, 4, 3, 2, k + 10);
    tick();
    start_a = 1'b0;
    wait_to(k + 10);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 64'({en_a, addr_a, pa.valid, pa.pixel, sof_a, eol_a,
                        busy_a, done_a}), 64'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    k = cyc;
    start_a = 1'b1;
    push_frame(0, k, 4, 3, 2, NOCUT);
    tick();
    start_a = 1'b0;
    wait_to(k + 25);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rq%0d_left", i), 64'(rq[i].size()), 64'(0));
      chk($sformatf("vq%0d_left", i), 64'(vq[i].size()), 64'(0));
      chk($sformatf("dq%0d_left", i), 64'(dq[i].size()), 64'(0));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
